// File: rtl/imm_decode_stage.sv
// Immediate decode stage: extracts the RISC-V immediate for the selected format
// and buffers {imm, fmt, illegal, tag} in a 2-entry skid FIFO with a registered in_ready.
module imm_decode_stage #(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      illegal_cnt
);

    localparam logic [2:0] FMT_I     = 3'd0;
    localparam logic [2:0] FMT_S     = 3'd1;
    localparam logic [2:0] FMT_B     = 3'd2;
    localparam logic [2:0] FMT_U     = 3'd3;
    localparam logic [2:0] FMT_J     = 3'd4;
    localparam logic [2:0] FMT_SHAMT = 3'd5;
    localparam logic [2:0] FMT_CSRI  = 3'd6;
    localparam logic [2:0] FMT_INV   = 3'd7;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [2:0]        auto_fmt_p0;
    logic [2:0]        fmt_p0;
    logic              ill_p0;
    logic signed [31:0] imm32_p0;
    logic signed [XLEN-1:0] imm_p0;
    logic              shamt_hi_p0;

    // Stage p0: combinational decode ahead of storage
    always_comb begin
        auto_fmt_p0 = FMT_INV;
        case (in_inst[6:0])
            7'b0000011, 7'b1100111: auto_fmt_p0 = FMT_I;
            7'b0010011: auto_fmt_p0 = (in_inst[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
            7'b0100011: auto_fmt_p0 = FMT_S;
            7'b1100011: auto_fmt_p0 = FMT_B;
            7'b0110111, 7'b0010111: auto_fmt_p0 = FMT_U;
            7'b1101111: auto_fmt_p0 = FMT_J;
            7'b1110011: auto_fmt_p0 = in_inst[14] ? FMT_CSRI : FMT_I;
            default: auto_fmt_p0 = FMT_INV;
        endcase
    end

    assign fmt_p0      = AUTO_DECODE ? auto_fmt_p0 : in_sel;
    assign ill_p0      = (fmt_p0 == FMT_INV);
    assign shamt_hi_p0 = (XLEN == 64) ? in_inst[25] : 1'b0;

    // Every format fits a signed 32-bit value; widening to XLEN is a sign-extending cast.
    always_comb begin
        imm32_p0 = 32'sd0;
        case (fmt_p0)
            FMT_I:     imm32_p0 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S:     imm32_p0 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B:     imm32_p0 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                   in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U:     imm32_p0 = {in_inst[31:12], 12'b0};
            FMT_J:     imm32_p0 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                   in_inst[20], in_inst[30:21], 1'b0};
            FMT_SHAMT: imm32_p0 = {26'b0, shamt_hi_p0, in_inst[24:20]};
            FMT_CSRI:  imm32_p0 = {27'b0, in_inst[19:15]};
            default:   imm32_p0 = 32'sd0;
        endcase
    end

    assign imm_p0 = XLEN'(imm32_p0);

    logic [1:0]        count;
    logic [1:0]        count_nxt;
    logic              accept;
    logic              consume;
    logic              head_from_in;
    logic              head_from_skid;
    logic              skid_load;
    logic [XLEN-1:0]   skid_imm_p1;
    logic [2:0]        skid_fmt_p1;
    logic              skid_ill_p1;
    logic [TAG_W-1:0]  skid_tag_p1;

    assign accept         = in_valid & in_ready & ~flush;
    assign consume        = out_valid & out_ready;
    assign head_from_in   = accept & ((count == 2'd0) | consume);
    assign head_from_skid = consume & (count == 2'd2);
    assign skid_load      = accept & (count == 2'd1) & ~consume;

    always_comb begin
        count_nxt = count;
        case ({accept, consume})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // Stage p1: head register drives the outputs; in_ready is precomputed from next occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= 2'd0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            illegal_cnt <= 16'd0;
            out_imm     <= '0;
            out_fmt     <= 3'd0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else begin
            if (accept && ill_p0) begin
                illegal_cnt <= sat_inc(illegal_cnt);
            end
            if (flush) begin
                count     <= 2'd0;
                out_valid <= 1'b0;
                in_ready  <= 1'b1;
            end else begin
                count     <= count_nxt;
                out_valid <= (count_nxt != 2'd0);
                in_ready  <= (count_nxt < 2'd2);
                if (head_from_in) begin
                    out_imm     <= imm_p0;
                    out_fmt     <= fmt_p0;
                    out_illegal <= ill_p0;
                    out_tag     <= in_tag;
                end else if (head_from_skid) begin
                    out_imm     <= skid_imm_p1;
                    out_fmt     <= skid_fmt_p1;
                    out_illegal <= skid_ill_p1;
                    out_tag     <= skid_tag_p1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_imm_p1 <= imm_p0;
            skid_fmt_p1 <= fmt_p0;
            skid_ill_p1 <= ill_p0;
            skid_tag_p1 <= in_tag;
        end
    end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: output immediate width; only 32 or 64 are legal.
REQ-002 SHALL have parameter TAG_W, default 32: sideband tag width (e.g. PC).
REQ-003 SHALL have parameter AUTO_DECODE, default 1: 1 = format derived from the opcode; 0 = format taken from in_sel.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1: discard all buffered entries.
REQ-007 SHALL have port in_valid, input, 1: input entry present.
REQ-008 SHALL have port in_ready, output, 1: stage can accept an entry.
REQ-009 SHALL have port in_inst, input, 32: full instruction word.
REQ-010 SHALL have port in_sel, input, 3: explicit format, used only when AUTO_DECODE=0.
REQ-011 SHALL have port in_tag, input, TAG_W: sideband data, passed through unchanged.
REQ-012 SHALL have port out_valid, output, 1: output entry present.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts the output entry.
REQ-014 SHALL have port out_imm, output, XLEN: decoded immediate.
REQ-015 SHALL have port out_fmt, output, 3: resolved format code.
REQ-016 SHALL have port out_illegal, output, 1: no legal immediate format.
REQ-017 SHALL have port out_tag, output, TAG_W: tag of the output entry.
REQ-018 SHALL have port illegal_cnt, output, 16: saturating count of illegal entries accepted.

Function
REQ-019 Format codes SHALL be: 000 I, 001 S, 010 B, 011 U, 100 J, 101 SHAMT, 110 CSRI, 111 invalid.
REQ-020 Immediate extraction SHALL follow the standard RISC-V formats, taken from in_inst, as follows.
- I: inst[31:20], sign-extended.
- S: {inst[31:25], inst[11:7]}, sign-extended.
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
- U: {inst[31:12], 12'b0}, sign-extended to XLEN.
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
- SHAMT: inst[24:20] when XLEN=32, inst[25:20] when XLEN=64, zero-extended.
- CSRI: inst[19:15], zero-extended.
- invalid: immediate 0 and illegal=1.
REQ-021 When AUTO_DECODE=1, the format SHALL be selected from opcode inst[6:0] as follows.
- 0000011 and 1100111: I.
- 0010011: SHAMT when funct3 inst[14:12] is 001 or 101, otherwise I.
- 0100011: S.
- 1100011: B.
- 0110111 and 0010111: U.
- 1101111: J.
- 1110011: CSRI when inst[14]=1, otherwise I.
- Any other opcode: invalid.
REQ-022 When AUTO_DECODE=0, in_sel=111 SHALL produce invalid; all other in_sel codes SHALL apply the REQ-020 extraction for that code directly.
REQ-023 An entry SHALL be accepted on a rising clk edge where in_valid=1 and in_ready=1.
REQ-024 An entry SHALL be consumed on a rising clk edge where out_valid=1 and out_ready=1.
REQ-025 The stage SHALL hold a 2-entry FIFO (skid buffer) of {imm, fmt, illegal, tag}, with decode performed before storage.
REQ-026 Latency SHALL be 1 cycle: an entry accepted at edge N is on the outputs with out_valid=1 after edge N.
REQ-027 in_ready SHALL be a registered value equal to (occupancy < 2); it SHALL NOT depend combinationally on out_ready.
REQ-028 Simultaneous accept and consume SHALL leave occupancy unchanged, sustaining 1 entry per cycle.
REQ-029 Output entries SHALL leave in strict acceptance order.
REQ-030 While out_valid=1 and out_ready=0, out_imm, out_fmt, out_illegal and out_tag SHALL remain stable.
REQ-031 A flush sampled high at an edge SHALL empty the FIFO, and an entry offered in the same cycle SHALL be dropped.
REQ-032 After a flush, out_valid=0 and in_ready=1 SHALL hold from the next cycle.
REQ-033 illegal_cnt SHALL increment by 1 for each accepted entry with illegal=1, including entries later flushed.
REQ-034 illegal_cnt SHALL hold at 0xFFFF once reached.

Reset
REQ-035 rst_n=0 SHALL asynchronously set occupancy to 0, out_valid=0, in_ready=1, illegal_cnt=0, and out_imm, out_fmt, out_illegal, out_tag to 0.
REQ-036 Reset asserted mid-operation SHALL discard all buffered entries, with no output appearing after reset release until a new entry is accepted.

Verification
REQ-037 XLEN=32, AUTO_DECODE=1, inject 0xFFF00093, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, out_fmt=000, out_illegal=0.
REQ-038 Inject 0xFE112E23 -> out_imm=0xFFFFFFFC, out_fmt=001.
REQ-039 Inject 0x123450B7 -> out_imm=0x12345000, out_fmt=011.
REQ-040 XLEN=64, inject 0x800000B7 -> out_imm=0xFFFFFFFF80000000, out_fmt=011.
REQ-041 XLEN=64, inject 0x03F09093 (slli, shamt 63) -> out_imm=63, out_fmt=101.
REQ-042 out_ready=0, offer tags 1,2,3 back-to-back -> tags 1 and 2 accepted, in_ready=0 after the second accept, tag 3 held; then out_ready=1 -> tags 1,2,3 emitted in order with no gaps.
REQ-043 Inject 0x0000007F -> out_illegal=1, out_imm=0, out_fmt=111, illegal_cnt 0->1; force the count to 0xFFFF then inject another illegal entry -> illegal_cnt stays 0xFFFF.
REQ-044 With 2 entries buffered, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered entry is never emitted.
REQ-045 Assert rst_n=0 with 2 entries buffered -> outputs go to their reset values immediately, without waiting for a clk edge.
